// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: control/status bundle between a run sequencer and its host.
// CPU_RUN_CTRL_STEP_EN adds the single-step controls.
interface cpu_run_ctrl_if #(parameter int CNT_W = 32);
  logic start, clear, cpu_stop;
  logic cpu_en, core_rst_n, running, done, timed_out;
  logic [CNT_W-1:0] cycle_count;
`ifdef CPU_RUN_CTRL_STEP_EN
  logic step_mode, step;
  modport master (output start, clear, cpu_stop, step_mode, step,
                  input cpu_en, core_rst_n, running, done, timed_out, cycle_count);
  modport slave (input start, clear, cpu_stop, step_mode, step,
                 output cpu_en, core_rst_n, running, done, timed_out, cycle_count);
`else
  modport master (output start, clear, cpu_stop,
                  input cpu_en, core_rst_n, running, done, timed_out, cycle_count);
  modport slave (input start, clear, cpu_stop,
                 output cpu_en, core_rst_n, running, done, timed_out, cycle_count);
`endif
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: arms, clocks (via enable) and watches a single-cycle core until stop or watchdog.
// Optional single-step control is built when CPU_RUN_CTRL_STEP_EN is defined.
module cpu_run_ctrl #(
  parameter int DIV = 3,
  parameter int ARM_CYCLES = 2,
  parameter int CNT_W = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input logic clk,
  input logic rst_n,
  cpu_run_ctrl_if.slave bus
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW = ARM_CYCLES > 1 ? $clog2(ARM_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ARM, RUN, HALT, TOUT} state_t;
  state_t state, state_d;
  logic [DW-1:0] div_cnt, div_d;
  logic [AW-1:0] arm_cnt, arm_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic start_q, start_rise, tick, freeze;
`ifdef CPU_RUN_CTRL_STEP_EN
  assign freeze = bus.step_mode;
  assign tick = freeze ? bus.step : div_cnt == DIV_LAST;
`else
  assign freeze = 1'b0;
  assign tick = div_cnt == DIV_LAST;
`endif
  assign start_rise = bus.start & ~start_q;
  assign bus.cpu_en = (state == RUN) & tick & ~bus.cpu_stop;
  assign bus.core_rst_n = state inside {RUN, HALT, TOUT};
  assign bus.running = state == RUN;
  assign bus.done = state inside {HALT, TOUT};
  assign bus.timed_out = state == TOUT;
  assign bus.cycle_count = cnt;
  always_comb begin
    state_d = state;
    div_d = div_cnt;
    arm_d = arm_cnt;
    cnt_d = cnt;
    case (state)
      IDLE, HALT, TOUT: if (start_rise) begin
        state_d = ARM;
        arm_d = '0;
        cnt_d = '0;
      end
      ARM: begin
        arm_d = arm_cnt + 1'b1;
        if (arm_cnt == ARM_LAST) begin
          state_d = RUN;
          div_d = '0;
        end
      end
      RUN: begin
        div_d = (freeze || div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        if (bus.cpu_stop) state_d = HALT;
        else if (bus.cpu_en) begin
          cnt_d = &cnt ? cnt : cnt + 1'b1;
          if (TIMEOUT != 0 && cnt == TO_LAST) state_d = TOUT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d = '0;
      div_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      div_cnt <= '0;
      arm_cnt <= '0;
      cnt <= '0;
      start_q <= 1'b0;
    end else begin
      state <= state_d;
      div_cnt <= div_d;
      arm_cnt <= arm_d;
      cnt <= cnt_d;
      start_q <= bus.start;
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed plus random runs of two configurations against a phase-level model.
module tb_cpu_run_ctrl;
  localparam int IDLE_P = 0, ARM_P = 1, RUN_P = 2, HALT_P = 3, TOUT_P = 4;
  localparam int N = 3000;
  int dv[2] = '{3, 1};
  int am[2] = '{2, 1};
  longint tmo[2] = '{5, 0};
  longint mx[2] = '{64'hFFFF_FFFF, 7};
  int ph[2], ac[2], rc[2];
  longint mc[2];
  bit sq, rel;
  int checks = 0, errors = 0, cyc;
  logic clk = 0, rst_n = 1, start = 0, clear = 0, cpu_stop = 0, step_mode = 0, step = 0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(32)) b0();
  cpu_run_ctrl_if #(.CNT_W(3)) b1();
  assign b0.start = start;
  assign b0.clear = clear;
  assign b0.cpu_stop = cpu_stop;
  assign b1.start = start;
  assign b1.clear = clear;
  assign b1.cpu_stop = cpu_stop;
`ifdef CPU_RUN_CTRL_STEP_EN
  assign b0.step_mode = step_mode;
  assign b0.step = step;
  assign b1.step_mode = step_mode;
  assign b1.step = step;
`endif
  cpu_run_ctrl #(.DIV(3), .ARM_CYCLES(2), .CNT_W(32), .TIMEOUT(5)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  cpu_run_ctrl #(.DIV(1), .ARM_CYCLES(1), .CNT_W(3), .TIMEOUT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  function automatic bit m_en(int i);
    return ph[i] == RUN_P && !cpu_stop && (step_mode ? step : (rc[i] % dv[i] == dv[i] - 1));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = IDLE_P; ac[i] = 0; rc[i] = 0; mc[i] = 0;
    end
    sq = 0;
  endtask

  task automatic m_step();
    bit rise, en;
    rise = start && !sq;
    for (int i = 0; i < 2; i++) begin
      en = m_en(i);
      if (clear) begin
        ph[i] = IDLE_P; mc[i] = 0; rc[i] = 0;
      end else if (ph[i] == ARM_P) begin
        ac[i]++;
        if (ac[i] == am[i]) begin ph[i] = RUN_P; rc[i] = 0; end
      end else if (ph[i] == RUN_P) begin
        rc[i] = step_mode ? 0 : rc[i] + 1;
        if (cpu_stop) ph[i] = HALT_P;
        else if (en) begin
          if (mc[i] < mx[i]) mc[i]++;
          if (tmo[i] != 0 && mc[i] == tmo[i]) ph[i] = TOUT_P;
        end
      end else if (rise) begin
        ph[i] = ARM_P; ac[i] = 0; mc[i] = 0;
      end
    end
    sq = start;
  endtask

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0d, want %0d", n, cyc, act, exp);
    end
  endtask

  task automatic cmp_dut(int i, logic en, logic crn, logic run, logic dn, logic to, logic [63:0] cnt);
    chk($sformatf("d%0d cpu_en", i), 64'(en), 64'(m_en(i)));
    chk($sformatf("d%0d core_rst_n", i), 64'(crn), 64'(ph[i] >= RUN_P));
    chk($sformatf("d%0d running", i), 64'(run), 64'(ph[i] == RUN_P));
    chk($sformatf("d%0d done", i), 64'(dn), 64'(ph[i] >= HALT_P));
    chk($sformatf("d%0d timed_out", i), 64'(to), 64'(ph[i] == TOUT_P));
    chk($sformatf("d%0d cycle_count", i), cnt, 64'(mc[i]));
  endtask

  task automatic cmp_all();
    cmp_dut(0, b0.cpu_en, b0.core_rst_n, b0.running, b0.done, b0.timed_out, 64'(b0.cycle_count));
    cmp_dut(1, b1.cpu_en, b1.core_rst_n, b1.running, b1.done, b1.timed_out, 64'(b1.cycle_count));
  endtask

  task automatic lit();
    case (cyc)
      0: begin chk("lit reset core_rst_n", 64'(b0.core_rst_n), 0); chk("lit reset count", 64'(b0.cycle_count), 0); end
      7: chk("lit arm core_rst_n", 64'(b0.core_rst_n), 0);
      8: chk("lit run core_rst_n", 64'(b0.core_rst_n), 1);
      10, 13, 16, 22: chk("lit cpu_en pulse", 64'(b0.cpu_en), 1);
      11, 12: chk("lit cpu_en gap", 64'(b0.cpu_en), 0);
      17: chk("lit count 3", 64'(b0.cycle_count), 3);
      23: begin
        chk("lit timed_out", 64'(b0.timed_out), 1);
        chk("lit tout done", 64'(b0.done), 1);
        chk("lit tout count", 64'(b0.cycle_count), 5);
      end
      24: chk("lit tout no cpu_en", 64'(b0.cpu_en), 0);
      25: begin chk("lit d1 saturate", 64'(b1.cycle_count), 7); chk("lit d1 running", 64'(b1.running), 1); end
      27: begin chk("lit rearm count", 64'(b0.cycle_count), 0); chk("lit rearm core_rst_n", 64'(b0.core_rst_n), 0); end
      37: chk("lit stop suppress", 64'(b0.cpu_en), 0);
      38: begin
        chk("lit halt done", 64'(b0.done), 1);
        chk("lit halt running", 64'(b0.running), 0);
        chk("lit halt count", 64'(b0.cycle_count), 2);
      end
      41: begin chk("lit clear done", 64'(b0.done), 0); chk("lit clear core_rst_n", 64'(b0.core_rst_n), 0); end
      43: chk("lit edge consumed", 64'(b0.core_rst_n), 0);
`ifdef CPU_RUN_CTRL_STEP_EN
      52, 56, 60: chk("lit step cpu_en", 64'(b0.cpu_en), 1);
      53: chk("lit step gap", 64'(b0.cpu_en), 0);
      61: chk("lit step count", 64'(b0.cycle_count), 3);
`endif
      default: ;
    endcase
  endtask

  task automatic drive();
    if (cyc < 70) begin
      start = (cyc >= 5 && cyc < 25) || (cyc >= 26 && cyc < 39) || (cyc >= 40 && cyc < 46) || cyc >= 47;
      clear = cyc == 40 || cyc == 45;
      cpu_stop = cyc == 37;
`ifdef CPU_RUN_CTRL_STEP_EN
      step_mode = cyc >= 45 && cyc < 62;
      step = cyc == 52 || cyc == 56 || cyc == 60;
`endif
    end else begin
      if ($urandom_range(7) == 0) start = ~start;
      clear = $urandom_range(63) == 0;
      cpu_stop = $urandom_range(19) == 0;
`ifdef CPU_RUN_CTRL_STEP_EN
      if ($urandom_range(49) == 0) step_mode = ~step_mode;
      step = $urandom_range(3) == 0;
`endif
    end
  endtask

  initial begin
    #1 rst_n = 0;
    m_reset();
    rel = 0;
    for (cyc = 0; cyc < N; cyc++) begin
      @(negedge clk);
      if (cyc == 2 || rel) begin rst_n = 1; rel = 0; end
      drive();
      #1;
      cmp_all();
      lit();
      @(posedge clk);
      if (rst_n) m_step();
      if (cyc == 1000 || cyc == 2000) begin
        #2 rst_n = 0;
        m_reset();
        #1 cmp_all();
        rel = 1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run controller for the KGPRISC single-cycle core; it replaces free-running stimulus clocks with a synthesizable sequencer.
- From a single fast clock it generates a core clock-enable at a programmable divide ratio and holds the core in reset during an arm window.
- It runs the core until the core's stop output asserts or a cycle watchdog expires, and reports status and an executed-cycle count.

Parameters:
- DIV, 3, fast-clock cycles per core cycle; legal range is 1 or more (DIV=1 means cpu_en every cycle while running).
- ARM_CYCLES, 2, fast-clock cycles core_rst_n is held low after a start edge; legal range is 1 or more.
- CNT_W, 32, width of cycle_count.
- TIMEOUT, 1000000, core cycles before the watchdog fires; 0 disables the watchdog; must be at most 2^CNT_W-1.

Ports:
- clk  in  1  fast clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; a rising edge (registered compare) launches a run.
- clear  in  1  synchronous pulse; returns the block to IDLE from any state.
- cpu_stop  in  1  halt indication from the core.
- cpu_en  out  1  core clock-enable, one fast cycle wide.
- core_rst_n  out  1  active-low reset to the core.
- running  out  1  high in RUN.
- done  out  1  high in HALT or TOUT.
- timed_out  out  1  high in TOUT.
- cycle_count  out  CNT_W  core cycles executed in the current or last run.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, div_cnt=0, cycle_count=0, start_q=0.
  - core_rst_n=0, cpu_en=0, running=0, done=0, timed_out=0.
- start_rise = start & ~start_q, where start_q is registered every cycle.
- States: IDLE, ARM, RUN, HALT, TOUT.
- IDLE:
  - core_rst_n=0.
  - On start_rise: go to ARM, arm_cnt=0, cycle_count=0.
- ARM:
  - core_rst_n=0; arm_cnt increments each cycle.
  - When arm_cnt==ARM_CYCLES-1: go to RUN, div_cnt=0.
- RUN:
  - core_rst_n=1, running=1.
  - div_cnt counts 0..DIV-1 and wraps.
  - cpu_en = (state==RUN) & (div_cnt==DIV-1) & ~cpu_stop. This is a combinational decode of registered state.
  - Each cpu_en cycle: cycle_count increments.
  - cpu_stop=1 in any RUN cycle: next state HALT, and cpu_en is suppressed in that same cycle.
  - Watchdog: TIMEOUT!=0 and a cpu_en fires with cycle_count==TIMEOUT-1. cycle_count becomes TIMEOUT and the next state is TOUT.
  - If cpu_stop and the watchdog condition coincide, cpu_stop wins: cpu_en is suppressed, so the next state is HALT.
  - With TIMEOUT=0, cycle_count saturates at all-ones.
- HALT / TOUT:
  - core_rst_n=1 (core state stays inspectable); cpu_en=0.
  - done=1; timed_out=1 only in TOUT.
  - cycle_count holds.
  - start_rise: go to ARM and clear cycle_count.
- Priority:
  - clear has highest priority after rst_n; it forces IDLE and zeroes cycle_count and div_cnt.
  - If clear and start_rise coincide, clear wins. The start edge is consumed because start_q still updates.
- start_rise during ARM or RUN is ignored; a restart requires HALT, TOUT or IDLE.
- Latency:
  - Start edge to first core_rst_n=1 is 1+ARM_CYCLES cycles.
  - First cpu_en comes DIV-1 cycles after RUN entry.

Optional Feature:
- Macro: CPU_RUN_CTRL_STEP_EN.
- When defined, add two ports: step_mode in 1, and step in 1 (pulse).
- With step_mode=1 in RUN:
  - The divider is frozen at 0.
  - cpu_en = step & ~cpu_stop, one enable per step cycle.
  - cycle_count and the watchdog behave as in normal RUN.
- With step_mode=0, behaviour is identical to the build without the macro.
- When the macro is undefined, the ports are absent and the logic is not generated.

Test Plan:
- DIV=3, ARM_CYCLES=2: rst_n released, start 0->1 at cycle 5.
  - core_rst_n goes high at cycle 8.
  - cpu_en pulses at cycles 10, 13, 16, and so on; cycle_count=3 after cycle 16.
- cpu_stop asserted on a cycle where div_cnt==2:
  - No cpu_en on that cycle; the next cycle shows done=1, running=0.
  - cycle_count is frozen.
- TIMEOUT=5, cpu_stop held 0:
  - Exactly 5 cpu_en pulses occur, then timed_out=1, done=1, cycle_count=5.
  - No further cpu_en.
- In HALT, toggle start 0->1:
  - ARM is re-entered and cycle_count reads 0.
  - clear asserted together with start_rise gives IDLE, with done=0.
- rst_n pulsed low mid-RUN (asynchronous, off-edge):
  - All outputs return to their reset values immediately.
  - No cpu_en until a new start edge.
- With CPU_RUN_CTRL_STEP_EN, step_mode=1, three step pulses spaced 4 cycles apart:
  - Exactly 3 cpu_en pulses, aligned to the step pulses; cycle_count=3.
